// File: rtl/cocotb_array_pipe_pkg.sv
// cocotb_array_pipe_pkg: transform modes and entry-width helper for cocotb_array_pipe
package cocotb_array_pipe_pkg;
  typedef enum logic [1:0] {MODE_PASS, MODE_TRANSPOSE, MODE_REVERSE, MODE_INVERT} mode_e;
  localparam int MODE_W = 2;
  function automatic int entry_width(input int dim, input int w, input bit par);
    return dim * dim * w + MODE_W + (par ? dim * dim : 0);
  endfunction
endpackage

// File: rtl/cocotb_array_pipe_fifo.sv
// cocotb_array_pipe_fifo: DEPTH x WIDTH flop FIFO with synchronous flush and occupancy count
module cocotb_array_pipe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic push, pop;
  assign wr_ready = count != CW'(DEPTH);
  assign rd_valid = count != '0;
  assign push = wr_valid && wr_ready;
  assign pop = rd_valid && rd_ready;
  assign rd_data = mem[rptr];
  // storage, pointers and count; flush drops any same-cycle push or pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem <= '{default: '0};
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wr_data;
        wptr <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/cocotb_array_pipe.sv
// cocotb_array_pipe: DIM x DIM array transform into a FIFO; COCOTB_ARRAY_PIPE_PARITY_EN adds out_parity
module cocotb_array_pipe
  import cocotb_array_pipe_pkg::*;
#(
  parameter int W = 3,
  parameter int DIM = 3,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [W-1:0]           in_arr [DIM][DIM],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_arr [DIM][DIM],
  output logic [1:0]             out_mode,
  output logic [$clog2(DEPTH):0] out_count
`ifdef COCOTB_ARRAY_PIPE_PARITY_EN
  ,
  output logic [DIM*DIM-1:0]     out_parity
`endif
);
`ifdef COCOTB_ARRAY_PIPE_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int DW = DIM * DIM * W;
  localparam int WIDTH = entry_width(DIM, W, PAR);
  logic [WIDTH-1:0] wr_data, rd_data;
  mode_e mode;
  assign mode = mode_e'(in_mode);
  genvar r, c;
  for (r = 0; r < DIM; r++) begin : g_r
    for (c = 0; c < DIM; c++) begin : g_c
      logic [W-1:0] t;
      assign t = mode == MODE_TRANSPOSE ? in_arr[c][r] :
                 mode == MODE_REVERSE ? in_arr[DIM-1-r][DIM-1-c] :
                 mode == MODE_INVERT ? ~in_arr[r][c] : in_arr[r][c];
      assign wr_data[(r*DIM+c)*W +: W] = t;
      assign out_arr[r][c] = rd_data[(r*DIM+c)*W +: W];
`ifdef COCOTB_ARRAY_PIPE_PARITY_EN
      assign wr_data[DW+MODE_W+r*DIM+c] = ^t;
`endif
    end
  end
  assign wr_data[DW +: MODE_W] = in_mode;
  assign out_mode = rd_data[DW +: MODE_W];
`ifdef COCOTB_ARRAY_PIPE_PARITY_EN
  assign out_parity = rd_data[DW+MODE_W +: DIM*DIM];
`endif
  cocotb_array_pipe_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .wr_valid(in_valid),
    .wr_ready(in_ready),
    .wr_data(wr_data),
    .rd_valid(out_valid),
    .rd_ready(out_ready),
    .rd_data(rd_data),
    .count(out_count)
  );
endmodule

// File: tb/tb_cocotb_array_pipe.sv
// tb_cocotb_array_pipe: scoreboard bench for cocotb_array_pipe (W=3, DIM=3, DEPTH=4)
module tb_cocotb_array_pipe;
  localparam int W = 3;
  localparam int DIM = 3;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [26:0] d;
    logic [1:0]  m;
  } ent_t;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [1:0] in_mode = 0, out_mode;
  logic [W-1:0] in_arr [DIM][DIM];
  logic [W-1:0] out_arr [DIM][DIM];
  logic [2:0] out_count;
  logic [26:0] cur = '0, out_flat;
`ifdef COCOTB_ARRAY_PIPE_PARITY_EN
  logic [8:0] out_parity;
`endif
  ent_t exp_q[$];
  ent_t mon_e;
  int checks = 0, failures = 0;
  logic [1:0] modes [4] = '{2'd0, 2'd2, 2'd3, 2'd0};

  cocotb_array_pipe #(.W(W), .DIM(DIM), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_mode(in_mode),
    .in_arr(in_arr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_arr(out_arr),
    .out_mode(out_mode),
    .out_count(out_count)
`ifdef COCOTB_ARRAY_PIPE_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    out_flat = '0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        in_arr[r][c] = cur[(r*DIM+c)*W +: W];
        out_flat[(r*DIM+c)*W +: W] = out_arr[r][c];
      end
  end

  function automatic logic [26:0] mk(input int a, input int b);
    logic [26:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[k*3 +: 3] = 3'((k * a + b) % 8);
    return v;
  endfunction

  function automatic logic [26:0] model(input logic [26:0] a, input logic [1:0] m);
    logic [26:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[(r*3+c)*3 +: 3] = m == 2'd1 ? a[(c*3+r)*3 +: 3] :
                            m == 2'd2 ? a[((2-r)*3+(2-c))*3 +: 3] :
                            m == 2'd3 ? ~a[(r*3+c)*3 +: 3] : a[(r*3+c)*3 +: 3];
    return v;
  endfunction

  function automatic logic [8:0] par(input logic [26:0] d);
    logic [8:0] p;
    for (int k = 0; k < 9; k++) p[k] = ^d[k*3 +: 3];
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    logic acc;
    @(negedge clk);
    acc = in_valid && in_ready && !flush && !rst;
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back('{d: model(cur, in_mode), m: in_mode});
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (out_count == 0) break;
      step();
    end
    chk("drain_count", out_count, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_count"}, out_count, 0);
    chk({tag, "_arr"}, out_flat, 0);
    chk({tag, "_mode"}, out_mode, 0);
`ifdef COCOTB_ARRAY_PIPE_PARITY_EN
    chk({tag, "_parity"}, out_parity, 0);
`endif
  endtask

  // monitor: every pop the DUT will actually perform is compared against the queue head
  always @(negedge clk)
    if (!rst && !flush && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL mon_unexpected actual=%0h required=none", out_flat);
      end else begin
        checks--;
        mon_e = exp_q.pop_front();
        chk("mon_data", out_flat, mon_e.d);
        chk("mon_mode", out_mode, mon_e.m);
`ifdef COCOTB_ARRAY_PIPE_PARITY_EN
        chk("mon_parity", out_parity, par(mon_e.d));
`endif
      end
    end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk);
    #1;
    out_ready = 1;
    cur = mk(1, 0);
    in_mode = 2'd1;
    in_valid = 1;
    step();
    in_valid = 0;
    @(negedge clk);
    chk("t2_valid", out_valid, 1);
    chk("t2_arr01", out_arr[0][1], 3);
    chk("t2_arr10", out_arr[1][0], 1);
    chk("t2_mode", out_mode, 1);
    step();
    chk("t2_empty", out_valid, 0);
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      cur = mk(i + 2, i);
      in_mode = modes[i];
      step();
    end
    chk("t3_count", out_count, 4);
    chk("t3_in_ready", in_ready, 0);
    cur = mk(5, 3);
    in_mode = 2'd0;
    step();
    step();
    chk("t3_no5th", out_count, 4);
    out_ready = 1;
    step();
    chk("t4_full_pop_cnt", out_count, 3);
    chk("t4_ready_back", in_ready, 1);
    chk("t3_rev00", out_arr[0][0], 1);
    chk("t3_rev_mode", out_mode, 2);
    step();
    chk("t4_pushpop_cnt", out_count, 3);
    chk("t3_inv00", out_arr[0][0], 5);
    in_valid = 0;
    drain();
    out_ready = 0;
    in_valid = 1;
    cur = mk(7, 1);
    in_mode = 2'd1;
    step();
    cur = mk(2, 5);
    in_mode = 2'd3;
    step();
    chk("t5_count2", out_count, 2);
    flush = 1;
    cur = mk(1, 1);
    step();
    flush = 0;
    in_valid = 0;
    exp_q.delete();
    chk("t5_flush_valid", out_valid, 0);
    chk("t5_flush_count", out_count, 0);
    chk("t5_flush_ready", in_ready, 1);
    cur = '1;
    in_mode = 2'd0;
    in_valid = 1;
    out_ready = 1;
    step();
    in_valid = 0;
    chk("t5_all7", out_flat, 27'h7ffffff);
    drain();
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      cur = mk(i + 1, i * 2);
      in_mode = 2'(i);
      step();
    end
    in_valid = 0;
    chk("t6_count3", out_count, 3);
    rst = 1;
    #1;
    chk_reset("t6_rst");
    exp_q.delete();
    @(posedge clk);
    #1 rst = 0;
    out_ready = 1;
    in_valid = 1;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      cur = mk(i + 3, 7 - i);
      in_mode = 2'(i % 4);
      step();
      chk("t6_flow_cnt", out_count, 1);
    end
    for (int i = 0; i < 2 * DEPTH; i++) begin
      cur = mk(2 * i + 1, i);
      in_mode = 2'((i + 1) % 4);
      out_ready = i[0];
      step();
    end
    in_valid = 0;
    out_ready = 1;
    drain();
    chk("q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
